e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width in bits; SHALL be even and >= 8.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu; SHALL be >= 1.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div/divu; SHALL be >= 1.
REQ-004 Ports SHALL be:
 clk  in  1  single clock, rising edge.
 reset  in  1  asynchronous, active-high reset.
 A  in  WIDTH  operand rs / mthi-mtlo source.
 B  in  WIDTH  operand rt.
 MDUop  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none.
 start  in  1  launch strobe for MDUop 1-4, one cycle.
 busy  out  1  registered; high while an operation is in progress.
 HI  out  WIDTH  HI register.
 LO  out  WIDTH  LO register.

Function
REQ-005 Idle = busy low; a launch SHALL occur only when start=1, busy=0 and MDUop is 1-4.
REQ-006 On launch, A, B and MDUop SHALL be captured; busy SHALL rise at that edge and stay high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-007 At the edge ending the Nth busy cycle, HI/LO SHALL be written and busy SHALL fall together; results visible the cycle busy reads low.
REQ-008 A down-counter SHALL load N-1 on launch, decrement each busy cycle, and complete when busy and counter = 0.
REQ-009 mult: {HI,LO} = signed A * signed B, full 2*WIDTH product; multu: same, unsigned.
REQ-010 div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign; divu: unsigned quotient/remainder.
REQ-011 Signed div of most-negative value by -1: LO = most-negative value, HI = 0.
REQ-012 Divide by B = 0 (div or divu): launch and busy timing SHALL be normal; HI and LO SHALL remain unchanged at completion.
REQ-013 mthi/mtlo: when busy=0, HI (resp. LO) SHALL take A at the next edge, no busy; start not required.
REQ-014 Any start, mthi or mtlo while busy=1 SHALL be ignored; the in-flight operation SHALL be unaffected and HI/LO SHALL hold.
REQ-015 Operands changing after launch SHALL NOT affect the result.
REQ-016 start with MDUop 0, 5, 6 or 7-15 SHALL NOT launch; 5/6 still act per REQ-013.
REQ-017 Launch in the cycle busy falls (busy already low) SHALL be accepted; back-to-back operations SHALL have no gap cycle.
REQ-018 HI/LO SHALL change only at reset, completion, or mthi/mtlo.

Reset
REQ-019 reset=1 SHALL asynchronously force busy=0, HI=0, LO=0, counter=0 and captured operands=0.
REQ-020 Reset mid-operation SHALL abort it; no result SHALL be written after reset deasserts.
REQ-021 First launch SHALL be accepted at the first rising edge with reset low.

Configuration
REQ-022 Macro MDU_DIV_EN: when defined, div/divu SHALL behave per REQ-010 to REQ-012.
REQ-023 Without MDU_DIV_EN: no divider logic; MDUop 3/4 SHALL NOT launch; busy stays low and HI/LO hold.

Verification
REQ-024 WIDTH=32: mult A=32'hFFFFFFFE (-2), B=3, start -> busy high 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-025 multu A=32'hFFFFFFFF, B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001 after 5 busy cycles.
REQ-026 div A=-7 (32'hFFFFFFF9), B=2 -> 10 busy cycles, LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); then div A=32'h80000000, B=-1 -> LO=32'h80000000, HI=0.
REQ-027 mthi A=32'h12345678, then divu A=5, B=0 -> busy 10 cycles, HI stays 32'h12345678, LO unchanged.
REQ-028 Launch mult, pulse mtlo A=32'hDEAD in busy cycle 2, then reset in busy cycle 3 -> busy=0, HI=LO=0 immediately; no later write.
REQ-029 Build without MDU_DIV_EN: divu start -> busy stays 0, HI/LO hold; mult still completes per REQ-024.

Source files
------------

// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO registers; mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES (divider only if MDU_DIV_EN).
// Latency: result in HI/LO the cycle busy reads low; mthi/mtlo write HI/LO at the next edge when idle.
// Backpressure: none queued; start/mthi/mtlo presented while busy are dropped.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDUop,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic is_mul, is_div, launch, done;

    assign is_mul = (MDUop == OP_MULT) || (MDUop == OP_MULTU);
`ifdef MDU_DIV_EN
    assign is_div = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign launch = start && !busy && (is_mul || is_div);
    assign done   = busy && (cnt == '0);

    // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of an unsigned
    // multiply equal the signed product, so one multiplier serves mult and multu.
    logic                 mul_sgn;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;

    assign mul_sgn = (op_q == OP_MULT);
    assign a_ext   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
    assign b_ext   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
    assign prod    = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

    // Divide magnitudes then restore signs: quotient truncates toward zero, remainder
    // follows the dividend. MIN / -1 falls out as MIN with remainder 0.
    assign a_neg   = (op_q == OP_DIV) && a_q[WIDTH-1];
    assign b_neg   = (op_q == OP_DIV) && b_q[WIDTH-1];
    assign a_mag   = a_neg ? -a_q : a_q;
    assign b_mag   = b_neg ? -b_q : b_q;
    assign b_zero  = (b_q == '0);
    assign divisor = b_zero ? WIDTH'(1) : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem     = a_neg ? -r_mag : r_mag;
`endif

    logic             res_wr;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        res_wr = 1'b1;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            res_wr = !b_zero;
            res_hi = rem;
            res_lo = quo;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            if (launch) begin
                busy <= 1'b1;
                cnt  <= is_div ? DIV_LOAD : MUL_LOAD;
                op_q <= MDUop;
                a_q  <= A;
                b_q  <= B;
            end else if (done) begin
                busy <= 1'b0;
                if (res_wr) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end else if (busy) begin
                cnt <= cnt - 1'b1;
            end

            if (!busy && (MDUop == OP_MTHI)) HI <= A;
            if (!busy && (MDUop == OP_MTLO)) LO <= A;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu (WIDTH=32, 5 mult / 10 div cycles); div scenarios run only when MDU_DIV_EN is defined.
module tb_e_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A, B, HI, LO;
    logic [3:0]   MDUop;
    logic         start, busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] hi_m, lo_m;

    e_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop),
        .start(start), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: arithmetic on 64-bit integers, updating the expected HI/LO.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'd1: begin p = sa * sb; {hi_m, lo_m} = p; end
            4'd2: begin p = ua * ub; {hi_m, lo_m} = p; end
`ifdef MDU_DIV_EN
            4'd3: if (b != 0) begin lo_m = W'(sa / sb); hi_m = W'(sa % sb); end
            4'd4: if (b != 0) begin lo_m = W'(ua / ub); hi_m = W'(ua % ub); end
`endif
            default: ;
        endcase
    endtask

    // Called at a negedge; launches op and returns at the first negedge with busy low.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int cycles);
        A = a; B = b; MDUop = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUop = 4'd0; A = $urandom; B = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 60) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; MDUop = 4'd1; A = 32'd3; B = 32'd4;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (HI !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", HI); end
        n_cmp++; if (LO !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", LO); end
    endtask

    task automatic test_first_launch;
        int c;
        reset = 1'b0;
        run_op(4'd1, 32'd7, 32'd9, c);
        model_op(4'd1, 32'd7, 32'd9);
        n_cmp++; if (c != 5) begin n_bad++; $display("FAIL first_launch_cycles: got %0d want 5", c); end
        n_cmp++; if (LO !== 32'd63) begin n_bad++; $display("FAIL first_launch_lo: got %h want 3f", LO); end
    endtask

    task automatic test_mult_vectors;
        int c;
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, c);
        model_op(4'd1, 32'hFFFFFFFE, 32'd3);
        n_cmp++; if (c != 5) begin n_bad++; $display("FAIL mult_vec_cycles: got %0d want 5", c); end
        n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_vec_hi: got %h want ffffffff", HI); end
        n_cmp++; if (LO !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_vec_lo: got %h want fffffffa", LO); end
        run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, c);
        model_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_cmp++; if (c != 5) begin n_bad++; $display("FAIL multu_vec_cycles: got %0d want 5", c); end
        n_cmp++; if (HI !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_vec_hi: got %h want fffffffe", HI); end
        n_cmp++; if (LO !== 32'h00000001) begin n_bad++; $display("FAIL multu_vec_lo: got %h want 00000001", LO); end
    endtask

    task automatic test_mult_random;
        int c;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
            a  = $urandom;
            b  = $urandom;
            if (i == 3) a = 32'h80000000;
            if (i == 4) b = 32'h80000000;
            if (i == 5) a = 32'h0;
            run_op(op, a, b, c);
            model_op(op, a, b);
            n_cmp++; if (c != 5) begin n_bad++; $display("FAIL mul_rand_cycles[%0d]: got %0d want 5", i, c); end
            n_cmp++; if (HI !== hi_m) begin n_bad++; $display("FAIL mul_rand_hi[%0d] op%0d %h*%h: got %h want %h", i, op, a, b, HI, hi_m); end
            n_cmp++; if (LO !== lo_m) begin n_bad++; $display("FAIL mul_rand_lo[%0d] op%0d %h*%h: got %h want %h", i, op, a, b, LO, lo_m); end
        end
    endtask

    task automatic test_move;
        logic [W-1:0] v;
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            MDUop = (i % 2 == 0) ? 4'd5 : 4'd6;
            start = 1'($urandom_range(0, 1));
            A = v;
            if (i % 2 == 0) hi_m = v; else lo_m = v;
            @(negedge clk);
            MDUop = 4'd0; start = 1'b0;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL move_busy[%0d]: got %b want 0", i, busy); end
            n_cmp++; if (HI !== hi_m) begin n_bad++; $display("FAIL move_hi[%0d]: got %h want %h", i, HI, hi_m); end
            n_cmp++; if (LO !== lo_m) begin n_bad++; $display("FAIL move_lo[%0d]: got %h want %h", i, LO, lo_m); end
        end
    endtask

    task automatic test_ignore;
        int c;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        A = a; B = b; MDUop = 4'd1; start = 1'b1;
        c = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            c++;
            case (i)
                0: begin start = 1'b0; MDUop = 4'd6; A = 32'hDEAD; end
                1: begin start = 1'b1; MDUop = 4'd2; A = $urandom; B = $urandom; end
                2: begin start = 1'b0; MDUop = 4'd5; A = $urandom; end
                default: begin start = 1'b0; MDUop = 4'd0; end
            endcase
        end
        model_op(4'd1, a, b);
        n_cmp++; if (c != 5) begin n_bad++; $display("FAIL ignore_cycles: got %0d want 5", c); end
        n_cmp++; if (HI !== hi_m) begin n_bad++; $display("FAIL ignore_hi: got %h want %h", HI, hi_m); end
        n_cmp++; if (LO !== lo_m) begin n_bad++; $display("FAIL ignore_lo: got %h want %h", LO, lo_m); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_relaunch: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        logic [W-1:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        run_op(4'd2, a1, b1, c1);
        model_op(4'd2, a1, b1);
        n_cmp++; if (LO !== lo_m) begin n_bad++; $display("FAIL b2b_first_lo: got %h want %h", LO, lo_m); end
        run_op(4'd1, a2, b2, c2);
        model_op(4'd1, a2, b2);
        n_cmp++; if (c1 != 5 || c2 != 5) begin n_bad++; $display("FAIL b2b_cycles: got %0d,%0d want 5,5", c1, c2); end
        n_cmp++; if (HI !== hi_m) begin n_bad++; $display("FAIL b2b_hi: got %h want %h", HI, hi_m); end
        n_cmp++; if (LO !== lo_m) begin n_bad++; $display("FAIL b2b_lo: got %h want %h", LO, lo_m); end
    endtask

    task automatic test_nolaunch;
        for (int op = 0; op < 16; op++) begin
            if (op == 1 || op == 2 || op == 5 || op == 6) continue;
`ifdef MDU_DIV_EN
            if (op == 3 || op == 4) continue;
`endif
            A = $urandom; B = (op == 4) ? 32'd0 : $urandom; MDUop = 4'(op); start = 1'b1;
            @(negedge clk);
            start = 1'b0; MDUop = 4'd0;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nolaunch_busy op%0d: got %b want 0", op, busy); end
            repeat (11) @(negedge clk);
            n_cmp++; if (HI !== hi_m || LO !== lo_m) begin n_bad++; $display("FAIL nolaunch_hilo op%0d: got %h/%h want %h/%h", op, HI, LO, hi_m, lo_m); end
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div;
        int c;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, c);
        model_op(4'd3, 32'hFFFFFFF9, 32'd2);
        n_cmp++; if (c != 10) begin n_bad++; $display("FAIL div_vec_cycles: got %0d want 10", c); end
        n_cmp++; if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_vec: got %h/%h want ffffffff/fffffffd", HI, LO); end
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, c);
        model_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        n_cmp++; if (LO !== 32'h80000000 || HI !== 32'h0) begin n_bad++; $display("FAIL div_ovf: got %h/%h want 00000000/80000000", HI, LO); end
        A = 32'h12345678; MDUop = 4'd5; @(negedge clk); MDUop = 4'd0; hi_m = 32'h12345678;
        run_op(4'd4, 32'd5, 32'd0, c);
        n_cmp++; if (c != 10) begin n_bad++; $display("FAIL divu_zero_cycles: got %0d want 10", c); end
        n_cmp++; if (HI !== 32'h12345678 || LO !== lo_m) begin n_bad++; $display("FAIL divu_zero: got %h/%h want 12345678/%h", HI, LO, lo_m); end
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) - 32'd5 : $urandom;
            if (i == 2) b = 32'd0;
            run_op(op, a, b, c);
            model_op(op, a, b);
            n_cmp++; if (c != 10) begin n_bad++; $display("FAIL div_rand_cycles[%0d]: got %0d want 10", i, c); end
            n_cmp++; if (HI !== hi_m || LO !== lo_m) begin n_bad++; $display("FAIL div_rand[%0d] op%0d %h/%h: got %h/%h want %h/%h", i, op, a, b, HI, LO, hi_m, lo_m); end
        end
    endtask
`endif

    task automatic test_reset_mid;
        A = $urandom; B = $urandom; MDUop = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUop = 4'd0;
        @(negedge clk);
        MDUop = 4'd6; A = 32'hDEAD;
        @(negedge clk);
        MDUop = 4'd0;
        #2 reset = 1'b1;
        #1;
        hi_m = '0; lo_m = '0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (HI !== 32'h0 || LO !== 32'h0) begin n_bad++; $display("FAIL rstmid_hilo: got %h/%h want 0/0", HI, LO); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin n_bad++; $display("FAIL rstmid_after: got busy %b %h/%h want 0 0/0", busy, HI, LO); end
    endtask

    initial begin
        test_reset();
        test_first_launch();
        test_mult_vectors();
        test_mult_random();
        test_move();
        test_ignore();
        test_back_to_back();
        test_nolaunch();
`ifdef MDU_DIV_EN
        test_div();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
